// File: rtl/key_event_encoder.sv
// key_event_encoder
//
// Sits behind the per-key debouncers and turns level changes on the key
// inputs into discrete note-on / note-off events. At most one event is
// generated per cycle; when several keys change together the lowest key
// index goes first. Events are buffered in a small FIFO and handed to the
// voice allocator over a valid/ready handshake.
//
// Ports:
//   clk         system clock
//   rst         synchronous, active-high reset
//   key_levels  debounced key levels, 1 = pressed, bit i = key i
//   evt_valid   head FIFO entry valid
//   evt_ready   consumer accepts head entry this cycle
//   evt_note    MIDI note of head entry (BASE_NOTE + key index)
//   evt_on      1 = note-on, 0 = note-off
//   held_mask   key states already reported as events
//   fifo_level  current FIFO occupancy, 0..FIFO_DEPTH

module key_event_encoder #(
  parameter int NUM_KEYS   = 8,
  parameter int BASE_NOTE  = 60,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_KEYS-1:0]         key_levels,
  output logic                        evt_valid,
  input  logic                        evt_ready,
  output logic [6:0]                  evt_note,
  output logic                        evt_on,
  output logic [NUM_KEYS-1:0]         held_mask,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Parameter sanity checks, evaluated at elaboration.
  if (NUM_KEYS < 1 || NUM_KEYS > 16) begin : g_bad_num_keys
    $error("key_event_encoder: NUM_KEYS must be in 1..16");
  end
  if (BASE_NOTE < 0 || BASE_NOTE + NUM_KEYS - 1 > 127) begin : g_bad_base_note
    $error("key_event_encoder: BASE_NOTE+NUM_KEYS-1 must not exceed 127");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("key_event_encoder: FIFO_DEPTH must be a power of two >= 2");
  end

  logic [NUM_KEYS-1:0] key_q;
  logic [NUM_KEYS-1:0] reported;
  logic [NUM_KEYS-1:0] diff;
  logic [NUM_KEYS-1:0] sel_onehot;
  logic [3:0]          sel_idx;
  logic                push;
  logic                pop;
  logic                push_on;
  logic [6:0]          push_note;
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count;
  logic [7:0]          fifo_mem [FIFO_DEPTH];
  logic [7:0]          head;

  // Keys whose current level has not yet been reported are pending.
  assign diff = key_q ^ reported;

  // Isolate the lowest pending key: x & -x keeps only the lowest set bit.
  assign sel_onehot = diff & (~diff + NUM_KEYS'(1));

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (sel_onehot[i]) sel_idx = 4'(i);
    end
  end

  assign push_on   = |(key_q & sel_onehot);
  assign push_note = 7'(BASE_NOTE) + {3'b000, sel_idx};

  // Full check uses the occupancy before any same-cycle pop, so a full
  // FIFO refuses a push even while it is being drained.
  assign push = (diff != '0) && (count < CNT_W'(FIFO_DEPTH));
  assign pop  = (count != '0) && evt_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      key_q    <= '0;
      reported <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      key_q <= key_levels;
      if (push) begin
        // Record the level that was just queued for the selected key only.
        reported <= (reported & ~sel_onehot) | (key_q & sel_onehot);
        wr_ptr   <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible while count != 0.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      fifo_mem[wr_ptr] <= {push_on, push_note};
    end
  end

  assign head       = fifo_mem[rd_ptr];
  assign evt_valid  = (count != '0);
  assign evt_note   = evt_valid ? head[6:0] : 7'd0;
  assign evt_on     = evt_valid & head[7];
  assign held_mask  = reported;
  assign fifo_level = count;

endmodule

// File: tb/tb_key_event_encoder.sv
module tb_key_event_encoder;

  localparam int NK = 8;
  localparam int BN = 60;
  localparam int FD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] key_levels;
  logic       evt_valid;
  logic       evt_ready;
  logic [6:0] evt_note;
  logic       evt_on;
  logic [7:0] held_mask;
  logic [2:0] fifo_level;

  int n_checks = 0;
  int n_fail   = 0;

  key_event_encoder #(
    .NUM_KEYS  (NK),
    .BASE_NOTE (BN),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_levels(key_levels),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_note  (evt_note),
    .evt_on    (evt_on),
    .held_mask (held_mask),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  // Reference model: the keys as seen one cycle late, the set of key states
  // already announced, and a queue of {on, note} events awaiting the consumer.
  logic [7:0] m_keyq;
  logic [7:0] m_rep;
  logic [7:0] m_q[$];

  task automatic model_edge();
    logic [7:0] pend;
    int         occ;
    if (rst) begin
      m_keyq = 8'h00;
      m_rep  = 8'h00;
      m_q.delete();
    end else begin
      pend = m_keyq ^ m_rep;
      occ  = m_q.size();
      if (occ > 0 && evt_ready) void'(m_q.pop_front());
      if (pend != 0 && occ < FD) begin
        for (int k = 0; k < NK; k++) begin
          if (pend[k]) begin
            m_q.push_back({m_keyq[k], 7'(BN + k)});
            m_rep[k] = m_keyq[k];
            break;
          end
        end
      end
      m_keyq = key_levels;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string name, input logic v, input logic [6:0] note,
                         input logic on, input logic [7:0] held, input logic [2:0] lvl);
    chk({name, ".valid"}, 32'(evt_valid), 32'(v));
    chk({name, ".note"},  32'(evt_note),  32'(note));
    chk({name, ".on"},    32'(evt_on),    32'(on));
    chk({name, ".held"},  32'(held_mask), 32'(held));
    chk({name, ".level"}, 32'(fifo_level), 32'(lvl));
  endtask

  task automatic chk_model(input string name);
    logic       v;
    logic [6:0] note;
    logic       on;
    v    = (m_q.size() != 0);
    note = v ? m_q[0][6:0] : 7'd0;
    on   = v ? m_q[0][7]   : 1'b0;
    chk_all(name, v, note, on, m_rep, 3'(m_q.size()));
  endtask

  task automatic do_reset();
    key_levels = 8'h00;
    evt_ready  = 1'b0;
    rst        = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic       rst;
    logic [7:0] keys;
    logic       ready;
    logic       exp_valid;
    logic [6:0] exp_note;
    logic       exp_on;
    logic [7:0] exp_held;
    logic [2:0] exp_level;
  } vec_t;

  vec_t vecs[17];

  initial begin
    int         n_ev;
    int         seen67;
    logic [6:0] got_notes[$];
    int         ready_pct;

    // rst keys rdy | valid note on held level
    vecs[0]  = '{1'b1, 8'h00, 1'b1, 1'b0, 7'd0,  1'b0, 8'h00, 3'd0};
    vecs[1]  = '{1'b0, 8'h04, 1'b1, 1'b0, 7'd0,  1'b0, 8'h00, 3'd0};
    vecs[2]  = '{1'b0, 8'h04, 1'b1, 1'b1, 7'd62, 1'b1, 8'h04, 3'd1};
    vecs[3]  = '{1'b0, 8'h04, 1'b1, 1'b0, 7'd0,  1'b0, 8'h04, 3'd0};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 7'd0,  1'b0, 8'h04, 3'd0};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 7'd62, 1'b0, 8'h00, 3'd1};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 7'd0,  1'b0, 8'h00, 3'd0};
    vecs[7]  = '{1'b0, 8'h2B, 1'b0, 1'b0, 7'd0,  1'b0, 8'h00, 3'd0};
    vecs[8]  = '{1'b0, 8'h2B, 1'b0, 1'b1, 7'd60, 1'b1, 8'h01, 3'd1};
    vecs[9]  = '{1'b0, 8'h2B, 1'b0, 1'b1, 7'd60, 1'b1, 8'h03, 3'd2};
    vecs[10] = '{1'b0, 8'h2B, 1'b0, 1'b1, 7'd60, 1'b1, 8'h0B, 3'd3};
    vecs[11] = '{1'b0, 8'h2B, 1'b0, 1'b1, 7'd60, 1'b1, 8'h2B, 3'd4};
    vecs[12] = '{1'b0, 8'h2B, 1'b0, 1'b1, 7'd60, 1'b1, 8'h2B, 3'd4};
    vecs[13] = '{1'b0, 8'h2B, 1'b1, 1'b1, 7'd61, 1'b1, 8'h2B, 3'd3};
    vecs[14] = '{1'b0, 8'h2B, 1'b1, 1'b1, 7'd63, 1'b1, 8'h2B, 3'd2};
    vecs[15] = '{1'b0, 8'h2B, 1'b1, 1'b1, 7'd65, 1'b1, 8'h2B, 3'd1};
    vecs[16] = '{1'b0, 8'h2B, 1'b1, 1'b0, 7'd0,  1'b0, 8'h2B, 3'd0};

    m_keyq = 8'h00;
    m_rep  = 8'h00;

    // Reset and idle
    rst        = 1'b1;
    key_levels = 8'h00;
    evt_ready  = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_all("reset", 1'b0, 7'd0, 1'b0, 8'h00, 3'd0);
    end
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("idle.valid", 32'(evt_valid), 32'd0);
    end

    // Table: single press/release, then simultaneous changes with backpressure
    for (int v = 0; v < 17; v++) begin
      rst        = vecs[v].rst;
      key_levels = vecs[v].keys;
      evt_ready  = vecs[v].ready;
      tick();
      chk_all($sformatf("vec%0d", v), vecs[v].exp_valid, vecs[v].exp_note,
              vecs[v].exp_on, vecs[v].exp_held, vecs[v].exp_level);
    end

    // Full FIFO with one pending key, then same-cycle pop
    do_reset();
    key_levels = 8'h1F;
    for (int c = 0; c < 6; c++) tick();
    chk_all("full", 1'b1, 7'd60, 1'b1, 8'h0F, 3'd4);
    evt_ready = 1'b1;
    tick();
    chk_all("full_pop", 1'b1, 7'd61, 1'b1, 8'h0F, 3'd3);
    tick();
    chk_all("full_pop_push", 1'b1, 7'd62, 1'b1, 8'h1F, 3'd3);
    evt_ready = 1'b0;

    // Pending cancellation while full
    do_reset();
    key_levels = 8'h0F;
    for (int c = 0; c < 5; c++) tick();
    key_levels = 8'h8F;
    tick();
    tick();
    chk_all("cancel_blocked", 1'b1, 7'd60, 1'b1, 8'h0F, 3'd4);
    key_levels = 8'h0F;
    tick();
    tick();
    evt_ready = 1'b1;
    n_ev      = 0;
    seen67    = 0;
    got_notes.delete();
    for (int c = 0; c < 10; c++) begin
      if (evt_valid) begin
        n_ev++;
        got_notes.push_back(evt_note);
        if (evt_note == 7'd67) seen67++;
      end
      tick();
    end
    chk("cancel.events", 32'(n_ev), 32'd4);
    chk("cancel.note67", 32'(seen67), 32'd0);
    chk("cancel.held7", 32'(held_mask[7]), 32'd0);
    for (int c = 0; c < 4; c++) begin
      if (c < got_notes.size()) chk($sformatf("cancel.order%0d", c), 32'(got_notes[c]), 32'(60 + c));
    end
    chk("cancel.level", 32'(fifo_level), 32'd0);

    // Reset mid-operation with a key held through it
    do_reset();
    key_levels = 8'h07;
    for (int c = 0; c < 4; c++) tick();
    chk("mid.level", 32'(fifo_level), 32'd3);
    key_levels = 8'h01;
    rst        = 1'b1;
    tick();
    chk_all("mid.rst", 1'b0, 7'd0, 1'b0, 8'h00, 3'd0);
    rst = 1'b0;
    tick();
    chk("mid.lat1", 32'(evt_valid), 32'd0);
    tick();
    chk_all("mid.evt", 1'b1, 7'd60, 1'b1, 8'h01, 3'd1);
    evt_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("mid.after", 32'(evt_valid), 32'd0);
    end

    // Randomised traffic against the queue model
    do_reset();
    ready_pct = 75;
    for (int c = 0; c < 4000; c++) begin
      if (c % 150 == 0) ready_pct = $urandom_range(0, 100);
      rst = ($urandom_range(0, 299) == 0);
      case ($urandom_range(0, 7))
        0:       key_levels[$urandom_range(0, 7)] ^= 1'b1;
        1:       key_levels ^= 8'($urandom_range(0, 255));
        default: ;
      endcase
      evt_ready = ($urandom_range(1, 100) <= ready_pct);
      tick();
      chk_model($sformatf("rand%0d", c));
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
